pipe_stage_elastic: RTL and testbench

- Parametrised, elastic successor to the fixed ID/EX latch.
- Carries one pipeline-stage payload per transfer, split into a control field (WB/M/EX bits) and a data field (register values, addresses, immediate).
- Uses a valid/ready handshake, a two-entry skid buffer, flush and bubble injection.
- Instantiated between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB), so a downstream stall no longer corrupts or drops in-flight instructions.

---
 rtl/pipe_stage_elastic_pkg.sv | 19 +
 rtl/pipe_stage_elastic_slot.sv | 36 +++
 rtl/pipe_stage_elastic.sv | 109 ++++++++++
 tb/tb_pipe_stage_elastic.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_elastic_pkg.sv
// Shared constants for the elastic pipeline stage: default inert control value,
// control-field bit positions and the number of storage slots per stage.
package pipe_pkg;

    localparam int STAGE_SLOTS = 2;

    localparam logic [7:0] CTRL_NOP_DFLT = 8'h00;

    // Control-field layout: WB bits on top, then M, then EX.
    localparam int WB_WRITE    = 7;
    localparam int WB_MEM2REG  = 6;
    localparam int M_READ      = 5;
    localparam int M_WRITE     = 4;
    localparam int EX_REGDST   = 3;
    localparam int EX_ALUSRC   = 2;
    localparam int EX_ALUOP_HI = 1;
    localparam int EX_ALUOP_LO = 0;

endpackage

// File: rtl/pipe_stage_elastic_slot.sv
// One storage slot of the elastic stage: a valid bit plus control and data
// registers, with independent load and clear (clear wins) enables.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int                CTRL_W   = 8,
    parameter int                DATA_W   = 128,
    parameter logic [CTRL_W-1:0] RST_CTRL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic              valid,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [DATA_W-1:0] q_data
);

    // Clear only drops the valid bit so the last data word stays visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid  <= 1'b0;
            q_ctrl <= RST_CTRL;
            q_data <= '0;
        end else if (clear) begin
            valid  <= 1'b0;
        end else if (load) begin
            valid  <= 1'b1;
            q_ctrl <= d_ctrl;
            q_data <= d_data;
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register: valid/ready handshake with a two-entry skid buffer,
// flush of all held entries and NOP bubble injection for load-use hazards.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int                CTRL_W   = 8,
    parameter int                DATA_W   = 128,
    parameter logic [CTRL_W-1:0] CTRL_NOP = CTRL_W'(CTRL_NOP_DFLT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    input  logic              inject_bubble,
    output logic [1:0]        occupancy
);

    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    logic              drain;
    logic              enq;
    logic [CTRL_W-1:0] enq_ctrl;
    logic [DATA_W-1:0] enq_data;
    logic              load_main;
    logic              clear_main;
    logic              load_skid;
    logic              clear_skid;
    logic [CTRL_W-1:0] main_d_ctrl;
    logic [DATA_W-1:0] main_d_data;

    // in_ready comes straight from the skid flop; only the bubble request gates it.
    assign in_ready = !skid_valid && !inject_bubble;
    assign drain    = main_valid && out_ready;

    // A bubble takes the place of the upstream payload in the enqueue path.
    assign enq      = (inject_bubble || in_valid) && !skid_valid && !flush;
    assign enq_ctrl = inject_bubble ? CTRL_NOP : in_ctrl;
    assign enq_data = inject_bubble ? '0 : in_data;

    always_comb begin
        load_main   = 1'b0;
        load_skid   = 1'b0;
        main_d_ctrl = enq_ctrl;
        main_d_data = enq_data;
        if (!flush) begin
            if (skid_valid) begin
                load_main   = drain;
                main_d_ctrl = skid_ctrl;
                main_d_data = skid_data;
            end else if (enq) begin
                load_main = !main_valid || drain;
                load_skid = main_valid && !drain;
            end
        end
        clear_main = flush || (drain && !load_main);
        clear_skid = flush || (skid_valid && drain);
    end

    pipe_slot #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .RST_CTRL (CTRL_NOP)
    ) u_main (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load_main),
        .clear  (clear_main),
        .d_ctrl (main_d_ctrl),
        .d_data (main_d_data),
        .valid  (main_valid),
        .q_ctrl (main_ctrl),
        .q_data (main_data)
    );

    pipe_slot #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .RST_CTRL (CTRL_NOP)
    ) u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load_skid),
        .clear  (clear_skid),
        .d_ctrl (enq_ctrl),
        .d_data (enq_data),
        .valid  (skid_valid),
        .q_ctrl (skid_ctrl),
        .q_data (skid_data)
    );

    // An empty main slot still presents an inert instruction downstream.
    assign out_valid = main_valid;
    assign out_ctrl  = main_valid ? main_ctrl : CTRL_NOP;
    assign out_data  = main_data;
    assign occupancy = 2'(main_valid) + 2'(skid_valid);

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed-vector and scoreboard bench for pipe_stage_elastic.
module tb_pipe_stage_elastic;

    localparam int CTRL_W = 8;
    localparam int DATA_W = 128;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic              flush;
    logic              inject_bubble;
    logic [1:0]        occupancy;

    int errors = 0;
    int checks = 0;

    pipe_stage_elastic #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .CTRL_NOP (8'h00)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_ctrl       (in_ctrl),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_ctrl      (out_ctrl),
        .out_data      (out_data),
        .flush         (flush),
        .inject_bubble (inject_bubble),
        .occupancy     (occupancy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic              iv;
        logic [CTRL_W-1:0] ic;
        logic [DATA_W-1:0] id;
        logic              ordy;
        logic              fl;
        logic              bb;
        logic              ev;
        logic [CTRL_W-1:0] ec;
        logic [DATA_W-1:0] ed;
        logic              cd;
        logic [1:0]        eo;
        logic              er;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic iv, logic [7:0] ic, logic [DATA_W-1:0] id,
                                logic ordy, logic fl, logic bb, logic ev,
                                logic [7:0] ec, logic [DATA_W-1:0] ed, logic cd,
                                logic [1:0] eo, logic er);
        vec_t v;
        v.iv = iv; v.ic = ic; v.id = id; v.ordy = ordy; v.fl = fl; v.bb = bb;
        v.ev = ev; v.ec = ec; v.ed = ed; v.cd = cd; v.eo = eo; v.er = er;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [7:0] ic,
                         input logic [DATA_W-1:0] id, input logic ordy,
                         input logic fl, input logic bb);
        in_valid      = iv;
        in_ctrl       = ic;
        in_data       = id;
        out_ready     = ordy;
        flush         = fl;
        inject_bubble = bb;
    endtask

    logic [CTRL_W-1:0] q_ctrl[$];
    logic [DATA_W-1:0] q_data[$];

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 8'h00, '0, 1'b0, 1'b0, 1'b0);
        #12;
        chk("reset_out_valid", 128'(out_valid), 128'd0);
        chk("reset_out_ctrl",  128'(out_ctrl),  128'd0);
        chk("reset_out_data",  out_data,        128'd0);
        chk("reset_occupancy", 128'(occupancy), 128'd0);
        chk("reset_in_ready",  128'(in_ready),  128'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming with out_ready held high: one transfer per cycle, occupancy 1.
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk(1, 8'(i), 128'(i * 16), 1, 0, 0, 1, 8'(i), 128'(i * 16), 1, 2'd1, 1));
        vecs.push_back(mk(0, 8'h00, 128'h0, 1, 0, 0, 0, 8'h00, 128'h0, 0, 2'd0, 1));
        // Backpressure: A to main, B to skid, C held upstream until drained.
        vecs.push_back(mk(1, 8'h11, 128'hA1, 0, 0, 0, 1, 8'h11, 128'hA1, 1, 2'd1, 1));
        vecs.push_back(mk(1, 8'h22, 128'hB2, 0, 0, 0, 1, 8'h11, 128'hA1, 1, 2'd2, 0));
        vecs.push_back(mk(1, 8'h33, 128'hC3, 0, 0, 0, 1, 8'h11, 128'hA1, 1, 2'd2, 0));
        vecs.push_back(mk(1, 8'h33, 128'hC3, 1, 0, 0, 1, 8'h22, 128'hB2, 1, 2'd1, 1));
        vecs.push_back(mk(1, 8'h33, 128'hC3, 1, 0, 0, 1, 8'h33, 128'hC3, 1, 2'd1, 1));
        vecs.push_back(mk(0, 8'h00, 128'h0, 1, 0, 0, 0, 8'h00, 128'h0, 0, 2'd0, 1));
        // Flush with both slots full and 0x44 offered: everything dropped, data held.
        vecs.push_back(mk(1, 8'h61, 128'h6161, 0, 0, 0, 1, 8'h61, 128'h6161, 1, 2'd1, 1));
        vecs.push_back(mk(1, 8'h62, 128'h6262, 0, 0, 0, 1, 8'h61, 128'h6161, 1, 2'd2, 0));
        vecs.push_back(mk(1, 8'h44, 128'h4444, 0, 1, 0, 0, 8'h00, 128'h6161, 1, 2'd0, 1));
        vecs.push_back(mk(0, 8'h00, 128'h0, 1, 0, 0, 0, 8'h00, 128'h6161, 1, 2'd0, 1));
        // Bubble pulse while 0x55 is offered: NOP first, then 0x55.
        vecs.push_back(mk(1, 8'h55, 128'h555, 1, 0, 1, 1, 8'h00, 128'h0, 1, 2'd1, 0));
        vecs.push_back(mk(1, 8'h55, 128'h555, 1, 0, 0, 1, 8'h55, 128'h555, 1, 2'd1, 1));
        vecs.push_back(mk(0, 8'h00, 128'h0, 1, 0, 0, 0, 8'h00, 128'h0, 0, 2'd0, 1));
        // Bubble lands in skid when main is stalled.
        vecs.push_back(mk(1, 8'h77, 128'h777, 0, 0, 0, 1, 8'h77, 128'h777, 1, 2'd1, 1));
        vecs.push_back(mk(0, 8'h00, 128'h0, 0, 0, 1, 1, 8'h77, 128'h777, 1, 2'd2, 0));
        vecs.push_back(mk(0, 8'h00, 128'h0, 1, 0, 0, 1, 8'h00, 128'h0, 1, 2'd1, 1));
        vecs.push_back(mk(0, 8'h00, 128'h0, 1, 0, 0, 0, 8'h00, 128'h0, 0, 2'd0, 1));

        foreach (vecs[k]) begin
            drive(vecs[k].iv, vecs[k].ic, vecs[k].id, vecs[k].ordy, vecs[k].fl, vecs[k].bb);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_out_valid", k), 128'(out_valid), 128'(vecs[k].ev));
            chk($sformatf("vec%0d_out_ctrl", k),  128'(out_ctrl),  128'(vecs[k].ec));
            if (vecs[k].cd)
                chk($sformatf("vec%0d_out_data", k), out_data, vecs[k].ed);
            chk($sformatf("vec%0d_occupancy", k), 128'(occupancy), 128'(vecs[k].eo));
            chk($sformatf("vec%0d_in_ready", k),  128'(in_ready),  128'(vecs[k].er));
        end

        // in_ready drops combinationally as soon as a bubble is requested.
        drive(1'b1, 8'h00, '0, 1'b1, 1'b0, 1'b1);
        #1;
        chk("bubble_in_ready_comb", 128'(in_ready), 128'd0);
        drive(1'b0, 8'h00, '0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("bubble_release_in_ready", 128'(in_ready), 128'd1);

        // Asynchronous reset mid-cycle with both slots occupied.
        drive(1'b1, 8'h71, 128'h71, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 8'h72, 128'h72, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("pre_reset_occupancy", 128'(occupancy), 128'd2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset_out_valid", 128'(out_valid), 128'd0);
        chk("async_reset_out_ctrl",  128'(out_ctrl),  128'd0);
        chk("async_reset_out_data",  out_data,        128'd0);
        chk("async_reset_occupancy", 128'(occupancy), 128'd0);
        chk("async_reset_in_ready",  128'(in_ready),  128'd1);
        drive(1'b0, 8'h00, '0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_out_valid", 128'(out_valid), 128'd0);
        chk("post_reset_occupancy", 128'(occupancy), 128'd0);

        // Random traffic against a FIFO scoreboard.
        for (int i = 0; i < 10000; i++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom),
                  {$urandom, $urandom, $urandom, $urandom},
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0), 1'b0);
            #1;
            if (flush) begin
                q_ctrl.delete();
                q_data.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (q_ctrl.size() == 0) begin
                        chk("rand_unexpected_output", 128'(out_valid), 128'd0);
                    end else begin
                        chk("rand_out_ctrl", 128'(out_ctrl), 128'(q_ctrl[0]));
                        chk("rand_out_data", out_data, q_data[0]);
                        void'(q_ctrl.pop_front());
                        void'(q_data.pop_front());
                    end
                end
                if (in_valid && in_ready) begin
                    q_ctrl.push_back(in_ctrl);
                    q_data.push_back(in_data);
                end
            end
            @(posedge clk); #1;
            chk("rand_occupancy", 128'(occupancy), 128'(q_ctrl.size()));
            chk("rand_out_valid", 128'(out_valid), 128'(q_ctrl.size() != 0));
            chk("rand_in_ready",  128'(in_ready),  128'(q_ctrl.size() < 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
